// File: rtl/mult_rr_scheduler.sv
// Round-robin share of one pipelined signed 32x32 multiplier among N_REQ requesters.
// Latency: handshake at edge E -> rsp_valid in the cycle after edge E+MUL_LAT+1.
// Backpressure: one grant per cycle, none while hold/rst; responses cannot be stalled.
module mult_rr_scheduler #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hold,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*32-1:0] req_in1,
  input  logic [N_REQ*32-1:0] req_in2,
  output logic [31:0]         mul_in1,
  output logic [31:0]         mul_in2,
  input  logic [63:0]         mul_out,
  output logic                rsp_valid,
  output logic [ID_W-1:0]     rsp_id,
  output logic [63:0]         rsp_data,
  output logic                busy
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] winner;
  logic [ID_W:0]   cand;
  logic            found;
  logic            grant;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;

  // Tag pipe runs alongside the multiplier; the last stage lines up with mul_out.
  logic            tag_vld [MUL_LAT+1];
  logic [ID_W-1:0] tag_id  [MUL_LAT+1];

  // Search from ptr upward (mod N_REQ) for the first valid requester and mux its operands.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N_REQ)) begin
        cand = cand - (ID_W+1)'(N_REQ);
      end
      if (!found && req_valid[cand[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[ID_W-1:0];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        sel_a = req_in1[32*i +: 32];
        sel_b = req_in2[32*i +: 32];
      end
    end
  end

  // Grant is suppressed by hold and by reset so no handshake can land during either.
  always_comb begin
    grant     = found & ~hold & ~rst;
    req_ready = grant ? (N_REQ'(1) << winner) : '0;
  end

  // Pointer moves past the winner only when a handshake actually happens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant) begin
      ptr <= (winner == ID_W'(N_REQ-1)) ? '0 : winner + ID_W'(1);
    end
  end

  // Operand registers hold their last value between grants; the stale product is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_in1 <= '0;
      mul_in2 <= '0;
    end else if (grant) begin
      mul_in1 <= sel_a;
      mul_in2 <= sel_b;
    end
  end

  // Shift {valid, id} through the pipe in step with the multiplier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= MUL_LAT; k++) begin
        tag_vld[k] <= 1'b0;
        tag_id[k]  <= '0;
      end
    end else begin
      tag_vld[0] <= grant;
      tag_id[0]  <= winner;
      for (int k = 1; k <= MUL_LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
    end
  end

  // Register the response when a valid tag meets its product; pulse lasts one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= tag_vld[MUL_LAT];
      if (tag_vld[MUL_LAT]) begin
        rsp_id   <= tag_id[MUL_LAT];
        rsp_data <= mul_out;
      end
    end
  end

  // Busy covers every tag stage plus the response being presented.
  always_comb begin
    busy = rsp_valid;
    for (int k = 0; k <= MUL_LAT; k++) begin
      busy = busy | tag_vld[k];
    end
  end

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Randomised and directed bench for mult_rr_scheduler against a queue-based reference.
// Latency: expects each response two edges after its handshake (MUL_LAT=1).
// Backpressure: checks grants per cycle under random valid/hold/reset patterns.
module tb_mult_rr_scheduler;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          hold;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*32-1:0] req_in1;
  logic [N*32-1:0] req_in2;
  logic [31:0]   mul_in1;
  logic [31:0]   mul_in2;
  logic [63:0]   mul_out;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [63:0]   rsp_data;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // drive values applied by step()
  logic          d_rst;
  logic          d_hold;
  logic [N-1:0]  d_vld;
  logic [31:0]   d_a [N];
  logic [31:0]   d_b [N];

  // reference model state
  typedef struct {
    int          id;
    logic [63:0] data;
    int          due;
  } exp_t;
  exp_t exp_q[$];
  int   mptr = 0;

  always #5 clk = ~clk;

  // behavioural one-cycle signed multiplier standing in for the shared datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mul_out <= '0;
    else     mul_out <= $signed(mul_in1) * $signed(mul_in2);
  end

  mult_rr_scheduler #(.N_REQ(N), .ID_W(2), .MUL_LAT(1)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2),
    .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_out(mul_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return 64'(sa * sb);
  endfunction

  // one clock: apply inputs at negedge, check grant/reset effects, then check outputs after the edge
  task automatic step();
    logic [N-1:0] exp_rdy;
    int           w;
    logic         exp_busy;
    @(negedge clk);
    rst       = d_rst;
    hold      = d_hold;
    req_valid = d_vld;
    for (int i = 0; i < N; i++) begin
      req_in1[32*i +: 32] = d_a[i];
      req_in2[32*i +: 32] = d_b[i];
    end
    #1;
    if (rst) begin
      exp_q.delete();
      mptr = 0;
      chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
    end
    exp_rdy = '0;
    w = -1;
    if (!rst && !hold) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (mptr + k) % N;
        if (w < 0 && req_valid[i]) w = i;
      end
    end
    if (w >= 0) begin
      exp_rdy[w] = 1'b1;
      exp_q.push_back('{id: w, data: prod(d_a[w], d_b[w]), due: cyc + 3});
      mptr = (w + 1) % N;
    end
    chk("req_ready", {60'd0, req_ready}, {60'd0, exp_rdy});
    @(posedge clk);
    #1;
    cyc++;
    exp_busy = (exp_q.size() != 0);
    if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("rsp_id", {62'd0, rsp_id}, 64'(exp_q[0].id));
      chk("rsp_data", rsp_data, exp_q[0].data);
      void'(exp_q.pop_front());
    end else begin
      chk("rsp_idle", {63'd0, rsp_valid}, 64'd0);
    end
    chk("busy", {63'd0, busy}, {63'd0, exp_busy});
  endtask

  task automatic clr();
    d_vld = '0;
    for (int i = 0; i < N; i++) begin
      d_a[i] = '0;
      d_b[i] = '0;
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    d_vld[i] = 1'b1;
    d_a[i]   = a;
    d_b[i]   = b;
  endtask

  task automatic idle(input int n);
    clr();
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    d_rst = 1'b1;
    idle(2);
    d_rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(3))
      0: return $urandom;
      1: return 32'($signed($urandom_range(16)) - 8);
      2: return 32'h8000_0000;
      default: return 32'h7fff_ffff;
    endcase
  endfunction

  initial begin
    rst = 1'b1; hold = 1'b0; req_valid = '0; req_in1 = '0; req_in2 = '0;
    d_hold = 1'b0;
    d_rst  = 1'b1;
    clr();

    // reset state
    idle(2);
    chk("rst_mul_in1", {32'd0, mul_in1}, 64'd0);
    chk("rst_mul_in2", {32'd0, mul_in2}, 64'd0);
    chk("rst_rsp_id", {62'd0, rsp_id}, 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    d_rst = 1'b0;

    // single request: 5 * -3 from requester 0
    idle(1);
    clr(); set_req(0, 32'd5, -32'sd3); step();
    idle(4);

    // all requesters valid from reset, operands (i+1, -2)
    do_reset();
    clr();
    for (int i = 0; i < N; i++) set_req(i, 32'(i + 1), -32'sd2);
    for (int k = 0; k < 8; k++) step();
    idle(3);

    // pointer priority: move ptr to 2, then 1 and 3 compete
    do_reset();
    clr(); set_req(1, 32'd1, 32'd1); step();
    clr(); set_req(1, -32'sd7, 32'd4); set_req(3, 32'd9, -32'sd2); step();
    clr(); set_req(1, -32'sd7, 32'd4); step();
    idle(3);

    // hold with two operations in flight
    clr(); set_req(0, -32'sd4, -32'sd3); step();
    clr(); set_req(1, -32'sd6, 32'd7); step();
    d_hold = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 32'(i + 10), 32'd3);
    for (int k = 0; k < 4; k++) step();
    d_hold = 1'b0;
    for (int k = 0; k < 2; k++) step();
    idle(3);

    // reset with two operations in flight; first grant afterwards from ptr 0
    clr(); set_req(2, 32'd11, 32'd12); step();
    clr(); set_req(3, 32'd13, 32'd14); step();
    d_rst = 1'b1; idle(1);
    d_rst = 1'b0;
    clr(); set_req(1, 32'd3, 32'd3); set_req(3, 32'd2, 32'd2); step();
    idle(4);

    // zero and large operands
    clr(); set_req(2, -32'sd5, 32'd0); set_req(3, 32'h0003_5AAB, 32'd1); step();
    clr(); set_req(3, 32'h0003_5AAB, 32'd1); step();
    idle(3);

    // randomised traffic with occasional hold and reset
    for (int k = 0; k < 600; k++) begin
      d_rst  = ($urandom_range(99) < 2);
      d_hold = ($urandom_range(99) < 15);
      for (int i = 0; i < N; i++) begin
        d_vld[i] = ($urandom_range(99) < 60);
        d_a[i]   = rand_op();
        d_b[i]   = rand_op();
      end
      step();
    end
    d_rst  = 1'b0;
    d_hold = 1'b0;
    idle(4);
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_rr_scheduler.md
# mult_rr_scheduler

Round-robin scheduler that shares one pipelined signed 32x32 multiplier (the team's `SimpleMultiplier` datapath) among `N_REQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one pair per cycle into the multiplier. It tags each issued operation with its requester ID and returns each 64-bit product on a shared response bus in issue order. It sits between the multiply clients and the single multiplier instance.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `ID_W`, 2: width of requester ID, equals ceil(log2(`N_REQ`)).
- `MUL_LAT`, 1: multiplier latency. `mul_out` is valid in the cycle after edge k+`MUL_LAT` for operands registered at edge k.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `hold`  in  1  when high, no new grants; in-flight operations still complete.
- `req_valid`  in  `N_REQ`  requester i has an operand pair.
- `req_ready`  out  `N_REQ`  one-hot grant; handshake on requester i = `req_valid[i] & req_ready[i]` at a rising edge.
- `req_in1`  in  `N_REQ`*32  packed signed operand A; requester i at [32i+31:32i].
- `req_in2`  in  `N_REQ`*32  packed signed operand B; same packing.
- `mul_in1`  out  32  registered operand A to the multiplier.
- `mul_in2`  out  32  registered operand B to the multiplier.
- `mul_out`  in  64  signed product from the multiplier.
- `rsp_valid`  out  1  one-cycle pulse per completed operation.
- `rsp_id`  out  `ID_W`  requester index of this response.
- `rsp_data`  out  64  signed product, passed through unmodified from `mul_out`.
- `busy`  out  1  high while any operation is in flight, including a response being presented.

## Operation
- **Arbitration**
  - Priority pointer `ptr`, 0..`N_REQ`-1.
  - The winner is the first index i, searching `ptr`, `ptr`+1, … modulo `N_REQ`, with `req_valid[i]` high.
  - `req_ready` is combinational: it is the one-hot winner, or all zeros when `hold`=1 or no request is valid.
  - On a handshake, `ptr` ← winner+1 modulo `N_REQ`. Without a handshake, `ptr` is unchanged.
- **Issue**
  - On a handshake, `mul_in1`/`mul_in2` are loaded with the winner's operands.
  - With no handshake they hold their previous values; the multiplier result in that case is ignored.
- **Tag pipeline**
  - A shift register of depth `MUL_LAT`+1 carries {valid, id}.
  - A handshake injects {1, winner}; otherwise it injects {0, x}.
- **Response**
  - When the tag reaches the end of the pipe, `rsp_valid`, `rsp_id` and `rsp_data` (= `mul_out`) are registered and held for exactly one cycle.
  - There is no backpressure on responses. Requesters must accept `rsp_valid` unconditionally.
- **Ordering**: responses return strictly in issue order. Throughput is one operation per cycle.
- **Arithmetic**: two's complement throughout; the product is not truncated or saturated.
- **Reset** (asynchronous, any time)
  - All tag valids cleared, in-flight results discarded.
  - `ptr`=0.
  - `mul_in1`=`mul_in2`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `busy`=0.
  - `req_ready`=0 while `rst` is high.
  - No stale response may appear after `rst` deasserts.
- **Boundary conditions**
  - `hold` rising while operations are in flight: they complete normally.
  - A request arriving the same cycle as a response: both proceed independently.
  - `ptr` wraps from `N_REQ`-1 to 0.

## Timing
- Handshake at edge E → `mul_in*` updated at E → `rsp_valid` high in the cycle after edge E+`MUL_LAT`+1. With the default `MUL_LAT`=1 this is 2 edges.
- `busy` is combinational OR of all tag valids and `rsp_valid`.
- `req_ready` depends combinationally on `req_valid`, `ptr`, `hold` and `rst` only; there is no path from `mul_out`.
- Continuous requests yield back-to-back `rsp_valid` with no bubbles.

## Test plan
- **Single request**: requester 0 only, in1=5, in2=-3, handshake at E → `rsp_valid` after E+2 with `rsp_id`=0, `rsp_data`=-15 (0xFFFFFFFFFFFFFFF1). Exactly one pulse; `busy` low afterwards.
- **All requesters valid** continuously from reset, operands (i+1, -2) → grants 0,1,2,3,0,1… one per cycle. Responses arrive back-to-back with ids 0,1,2,3 and data -2,-4,-6,-8.
- **Pointer priority**: reach `ptr`=2, then requesters 1 and 3 valid → 3 is granted first, then 1. Products 9*-2=-18 (id 3) and -7*4=-28 (id 1) return in that order.
- **Hold with work in flight**: assert `hold` with 2 operations in flight (-4*-3, -6*7) → `req_ready` stays 0. Responses 12 and -42 still emitted, then `busy`=0; releasing `hold` resumes grants from the saved `ptr`.
- **Reset mid-operation**: assert `rst` asynchronously with 2 operations in flight → `rsp_valid`=0 and `busy`=0 immediately. No response after release; the first grant goes to the lowest valid index (`ptr`=0).
- **Zero and large operand**: -5*0 → 0. 0x00035AAB * 1 → 0x0000000000035AAB, returned to the correct `rsp_id`.
